pos_loop_scheduler: RTL and testbench
=====================================

POS_LOOP_SCHEDULER -- requirements
Module: pos_loop_scheduler

Interface
REQ-001 Parameter N_WIDTH, default 32: width of every pose and velocity bus, signed two's complement.
REQ-002 Parameter Q_WIDTH, default 15: number of fractional bits of the fixed-point format.
REQ-003 Parameter PERIOD_CYCLES, default 500000: control-loop period in clocks (10 ms at 50 MHz); SHALL be >= SETTLE_CYCLES+4.
REQ-004 Parameter SETTLE_CYCLES, default 4: clocks allowed for the combinational position controller to settle; SHALL be >= 1.
REQ-005 Parameter V_MAX, default 32'h0000_8000 (1.0): velocity saturation magnitude.
REQ-006 Parameter POS_TOL, default 32'h0000_0148 (~0.01): at-goal tolerance, applied per axis to X and Y.
REQ-007 Port POS_LOOP_SCHEDULER_CLOCK_50, in, 1: the single clock; all state changes on the rising edge.
REQ-008 Port POS_LOOP_SCHEDULER_RESET_InLow, in, 1: reset, asynchronous assertion, active-low.
REQ-009 Port POS_LOOP_SCHEDULER_ENABLE_In, in, 1: loop run enable.
REQ-010 Ports POS_LOOP_SCHEDULER_TARGETX/TARGETY/TARGETTHETA_InBus, in, N_WIDTH: live target pose.
REQ-011 Ports POS_LOOP_SCHEDULER_CURRENTX/CURRENTY/CURRENTTHETA_InBus, in, N_WIDTH: live odometry pose.
REQ-012 Ports POS_LOOP_SCHEDULER_SMPTARGETX/Y/THETA_OutBus and SMPCURRENTX/Y/THETA_OutBus, out, N_WIDTH: latched pose driving the position controller.
REQ-013 Ports POS_LOOP_SCHEDULER_CTRLVX/CTRLVY/CTRLWZ_InBus, in, N_WIDTH: raw controller outputs.
REQ-014 Ports POS_LOOP_SCHEDULER_VX/VY/WZ_OutBus, out, N_WIDTH: registered, saturated velocity commands.
REQ-015 Port POS_LOOP_SCHEDULER_VALID_Out, out, 1: one-cycle pulse when new commands are presented.
REQ-016 Port POS_LOOP_SCHEDULER_ATGOAL_Out, out, 1: registered at-goal flag.
REQ-017 Port POS_LOOP_SCHEDULER_OVERRUN_Out, out, 1: one-cycle pulse when a tick is dropped.

Function
REQ-018 Period counter SHALL count 0..PERIOD_CYCLES-1 while ENABLE=1 and wrap to 0; tick = (counter==PERIOD_CYCLES-1) & ENABLE.
REQ-019 FSM states SHALL be IDLE, SAMPLE, SETTLE, CAPTURE.
REQ-020 IDLE->SAMPLE on the edge where tick=1; otherwise remain IDLE.
REQ-021 SAMPLE SHALL, on its edge, latch all six pose inputs into the SMP* outputs, clear the settle counter, and go to SETTLE.
REQ-022 SETTLE SHALL increment the settle counter each edge and go to CAPTURE on the edge where the counter equals SETTLE_CYCLES-1.
REQ-023 CAPTURE SHALL, on its edge, register the saturated CTRL* values into VX/VY/WZ, set VALID=1 for exactly one cycle, update ATGOAL, and return to IDLE.
REQ-024 Latency: VALID SHALL be high in the cycle following the edge 2+SETTLE_CYCLES edges after the tick edge.
REQ-025 Saturation: each velocity > +V_MAX SHALL output +V_MAX, each < -V_MAX SHALL output -V_MAX, otherwise pass unchanged; comparisons are signed.
REQ-026 At-goal: if |SMPTARGETX-SMPCURRENTX|<=POS_TOL and |SMPTARGETY-SMPCURRENTY|<=POS_TOL, CAPTURE SHALL set ATGOAL=1 and force VX=VY=WZ=0; otherwise ATGOAL=0. Differences are computed in N_WIDTH+1 bits.
REQ-027 A tick arriving while the FSM is not IDLE SHALL be dropped, and OVERRUN SHALL pulse for one cycle.
REQ-028 ENABLE=0 SHALL, on the next edge, clear the period counter, return the FSM to IDLE, zero VX/VY/WZ, and suppress VALID. SMP* and ATGOAL SHALL hold.
REQ-029 Pose inputs changing outside SAMPLE SHALL NOT affect SMP* outputs.

Reset
REQ-030 RESET_InLow=0 SHALL immediately force: FSM=IDLE, period and settle counters=0, all SMP*=0, VX/VY/WZ=0, VALID=0, ATGOAL=0, OVERRUN=0.
REQ-031 Reset asserted mid-cycle (any state) SHALL abort the cycle without a VALID pulse. The first tick after release SHALL occur PERIOD_CYCLES edges after release with ENABLE=1.

Verification (PERIOD_CYCLES=10, SETTLE_CYCLES=2, defaults otherwise)
REQ-032 Nominal: ENABLE=1, target=(1.0,0,0), current=0, CTRLVX=0.5 -> VALID pulses every 10 cycles, 4 edges after each tick; VX=32'h0000_4000, ATGOAL=0.
REQ-033 Saturation: CTRLVX=2.0, CTRLWZ=-3.0 -> VX=32'h0000_8000, WZ=32'hFFFF_8000.
REQ-034 At-goal: target-current=(0.005,-0.005), CTRLVY=0.3 -> ATGOAL=1, VX=VY=WZ=0 on VALID.
REQ-035 Sample isolation: change CURRENTX during SETTLE -> SMPCURRENTX unchanged until the next SAMPLE.
REQ-036 Disable/reset: drop ENABLE during SETTLE -> no VALID, outputs zeroed next edge. Pulse RESET_InLow low during SETTLE -> all outputs 0 asynchronously, next VALID 14 edges after release.
REQ-037 Overrun: force the FSM busy at a tick via a bench override of PERIOD_CYCLES=4 with SETTLE_CYCLES=2 -> OVERRUN pulses and the tick is dropped.

Source files
------------

// File: rtl/pos_loop_scheduler.sv
// Position-loop scheduler: paces a combinational position controller at a fixed period,
// samples the pose, waits for the controller to settle, then registers saturated velocity commands.
module pos_loop_scheduler #(
  parameter int                 N_WIDTH       = 32,
  parameter int                 Q_WIDTH       = 15,
  parameter int                 PERIOD_CYCLES = 500000,
  parameter int                 SETTLE_CYCLES = 4,
  parameter logic [N_WIDTH-1:0] V_MAX         = 32'h0000_8000,
  parameter logic [N_WIDTH-1:0] POS_TOL       = 32'h0000_0148
) (
  input  logic               POS_LOOP_SCHEDULER_CLOCK_50,
  input  logic               POS_LOOP_SCHEDULER_RESET_InLow,
  input  logic               POS_LOOP_SCHEDULER_ENABLE_In,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_TARGETX_InBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_TARGETY_InBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_TARGETTHETA_InBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_CURRENTX_InBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_CURRENTY_InBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_CURRENTTHETA_InBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_SMPTARGETX_OutBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_SMPTARGETY_OutBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_SMPTARGETTHETA_OutBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_SMPCURRENTX_OutBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_SMPCURRENTY_OutBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_SMPCURRENTTHETA_OutBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_CTRLVX_InBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_CTRLVY_InBus,
  input  logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_CTRLWZ_InBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_VX_OutBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_VY_OutBus,
  output logic [N_WIDTH-1:0] POS_LOOP_SCHEDULER_WZ_OutBus,
  output logic               POS_LOOP_SCHEDULER_VALID_Out,
  output logic               POS_LOOP_SCHEDULER_ATGOAL_Out,
  output logic               POS_LOOP_SCHEDULER_OVERRUN_Out
);

  localparam int PCW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PCW-1:0] PERIOD_LAST = PCW'(PERIOD_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic signed [N_WIDTH-1:0] VMAX_POS = $signed(V_MAX);
  localparam logic signed [N_WIDTH-1:0] VMAX_NEG = -$signed(V_MAX);

  if ((Q_WIDTH >= N_WIDTH) || (SETTLE_CYCLES < 1)) begin : g_param_check
    $error("pos_loop_scheduler: Q_WIDTH must be < N_WIDTH and SETTLE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  logic               clk_s;
  logic               rst_n_s;
  logic               enable_s;
  logic               tick_s;
  logic               at_goal_s;
  state_t             state_r;
  state_t             next_state_s;
  logic [PCW-1:0]     period_cnt_r;
  logic [SCW-1:0]     settle_cnt_r;
  logic [N_WIDTH-1:0] smp_tx_r, smp_ty_r, smp_tth_r;
  logic [N_WIDTH-1:0] smp_cx_r, smp_cy_r, smp_cth_r;
  logic [N_WIDTH-1:0] vx_r, vy_r, wz_r;
  logic               valid_r;
  logic               atgoal_r;
  logic               overrun_r;

  // Signed clamp of one velocity component to +/-V_MAX.
  function automatic logic [N_WIDTH-1:0] sat_vel(input logic [N_WIDTH-1:0] v);
    logic signed [N_WIDTH-1:0] vs;
    vs = $signed(v);
    if (vs > VMAX_POS) begin
      sat_vel = VMAX_POS;
    end else if (vs < VMAX_NEG) begin
      sat_vel = VMAX_NEG;
    end else begin
      sat_vel = v;
    end
  endfunction

  // One extra bit keeps the difference of two extreme poses from wrapping.
  function automatic logic within_tol(input logic [N_WIDTH-1:0] a, input logic [N_WIDTH-1:0] b);
    logic [N_WIDTH:0] diff;
    logic [N_WIDTH:0] mag;
    diff = {a[N_WIDTH-1], a} - {b[N_WIDTH-1], b};
    if (diff[N_WIDTH]) begin
      mag = -diff;
    end else begin
      mag = diff;
    end
    within_tol = (mag <= {1'b0, POS_TOL});
  endfunction

  assign clk_s     = POS_LOOP_SCHEDULER_CLOCK_50;
  assign rst_n_s   = POS_LOOP_SCHEDULER_RESET_InLow;
  assign enable_s  = POS_LOOP_SCHEDULER_ENABLE_In;
  assign tick_s    = enable_s && (period_cnt_r == PERIOD_LAST);
  assign at_goal_s = within_tol(smp_tx_r, smp_cx_r) && within_tol(smp_ty_r, smp_cy_r);

  // Free-running period counter, held at zero while disabled.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      period_cnt_r <= '0;
    end else if (!enable_s || (period_cnt_r == PERIOD_LAST)) begin
      period_cnt_r <= '0;
    end else begin
      period_cnt_r <= period_cnt_r + PCW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    if (!enable_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (tick_s) begin
            next_state_s = ST_SAMPLE;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_SAMPLE: next_state_s = ST_SETTLE;
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            next_state_s = ST_CAPTURE;
          end else begin
            next_state_s = ST_SETTLE;
          end
        end
        ST_CAPTURE: next_state_s = ST_IDLE;
        default:    next_state_s = ST_IDLE;
      endcase
    end
  end

  // Pose sampling, settle timing and registered command outputs.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      settle_cnt_r <= '0;
      smp_tx_r     <= '0;
      smp_ty_r     <= '0;
      smp_tth_r    <= '0;
      smp_cx_r     <= '0;
      smp_cy_r     <= '0;
      smp_cth_r    <= '0;
      vx_r         <= '0;
      vy_r         <= '0;
      wz_r         <= '0;
      valid_r      <= 1'b0;
      atgoal_r     <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      valid_r   <= 1'b0;
      overrun_r <= tick_s && (state_r != ST_IDLE);
      if (!enable_s) begin
        vx_r <= '0;
        vy_r <= '0;
        wz_r <= '0;
      end else begin
        case (state_r)
          ST_SAMPLE: begin
            smp_tx_r     <= POS_LOOP_SCHEDULER_TARGETX_InBus;
            smp_ty_r     <= POS_LOOP_SCHEDULER_TARGETY_InBus;
            smp_tth_r    <= POS_LOOP_SCHEDULER_TARGETTHETA_InBus;
            smp_cx_r     <= POS_LOOP_SCHEDULER_CURRENTX_InBus;
            smp_cy_r     <= POS_LOOP_SCHEDULER_CURRENTY_InBus;
            smp_cth_r    <= POS_LOOP_SCHEDULER_CURRENTTHETA_InBus;
            settle_cnt_r <= '0;
          end
          ST_SETTLE: settle_cnt_r <= settle_cnt_r + SCW'(1);
          ST_CAPTURE: begin
            valid_r  <= 1'b1;
            atgoal_r <= at_goal_s;
            if (at_goal_s) begin
              vx_r <= '0;
              vy_r <= '0;
              wz_r <= '0;
            end else begin
              vx_r <= sat_vel(POS_LOOP_SCHEDULER_CTRLVX_InBus);
              vy_r <= sat_vel(POS_LOOP_SCHEDULER_CTRLVY_InBus);
              wz_r <= sat_vel(POS_LOOP_SCHEDULER_CTRLWZ_InBus);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign POS_LOOP_SCHEDULER_SMPTARGETX_OutBus      = smp_tx_r;
  assign POS_LOOP_SCHEDULER_SMPTARGETY_OutBus      = smp_ty_r;
  assign POS_LOOP_SCHEDULER_SMPTARGETTHETA_OutBus  = smp_tth_r;
  assign POS_LOOP_SCHEDULER_SMPCURRENTX_OutBus     = smp_cx_r;
  assign POS_LOOP_SCHEDULER_SMPCURRENTY_OutBus     = smp_cy_r;
  assign POS_LOOP_SCHEDULER_SMPCURRENTTHETA_OutBus = smp_cth_r;
  assign POS_LOOP_SCHEDULER_VX_OutBus              = vx_r;
  assign POS_LOOP_SCHEDULER_VY_OutBus              = vy_r;
  assign POS_LOOP_SCHEDULER_WZ_OutBus              = wz_r;
  assign POS_LOOP_SCHEDULER_VALID_Out              = valid_r;
  assign POS_LOOP_SCHEDULER_ATGOAL_Out             = atgoal_r;
  assign POS_LOOP_SCHEDULER_OVERRUN_Out            = overrun_r;

endmodule

// File: tb/tb_pos_loop_scheduler.sv
// Directed bench for pos_loop_scheduler: a vector table for the per-period datapath plus
// hand-written sequences for sample isolation, disable, reset abort and overrun.
module tb_pos_loop_scheduler;

  logic        clk;
  logic        rst_n;
  logic        en, en2;
  logic [31:0] tx, ty, tth, cx, cy, cth, cvx, cvy, cwz;
  logic [31:0] s_tx, s_ty, s_tth, s_cx, s_cy, s_cth, vx, vy, wz;
  logic        valid, atgoal, ovr;
  logic [31:0] d2_stx, d2_sty, d2_stth, d2_scx, d2_scy, d2_scth, d2_vx, d2_vy, d2_wz;
  logic        d2_valid, d2_atgoal, d2_ovr;
  logic        ovr_seen;
  int          n_tests, n_fail;

  typedef struct {
    logic [31:0] tx, ty, cx, cy, cvx, cvy, cwz;
    logic [31:0] evx, evy, ewz;
    logic        eag;
  } vec_t;
  vec_t vecs[7];

  pos_loop_scheduler #(.PERIOD_CYCLES(10), .SETTLE_CYCLES(2)) dut (
    .POS_LOOP_SCHEDULER_CLOCK_50(clk),
    .POS_LOOP_SCHEDULER_RESET_InLow(rst_n),
    .POS_LOOP_SCHEDULER_ENABLE_In(en),
    .POS_LOOP_SCHEDULER_TARGETX_InBus(tx),
    .POS_LOOP_SCHEDULER_TARGETY_InBus(ty),
    .POS_LOOP_SCHEDULER_TARGETTHETA_InBus(tth),
    .POS_LOOP_SCHEDULER_CURRENTX_InBus(cx),
    .POS_LOOP_SCHEDULER_CURRENTY_InBus(cy),
    .POS_LOOP_SCHEDULER_CURRENTTHETA_InBus(cth),
    .POS_LOOP_SCHEDULER_SMPTARGETX_OutBus(s_tx),
    .POS_LOOP_SCHEDULER_SMPTARGETY_OutBus(s_ty),
    .POS_LOOP_SCHEDULER_SMPTARGETTHETA_OutBus(s_tth),
    .POS_LOOP_SCHEDULER_SMPCURRENTX_OutBus(s_cx),
    .POS_LOOP_SCHEDULER_SMPCURRENTY_OutBus(s_cy),
    .POS_LOOP_SCHEDULER_SMPCURRENTTHETA_OutBus(s_cth),
    .POS_LOOP_SCHEDULER_CTRLVX_InBus(cvx),
    .POS_LOOP_SCHEDULER_CTRLVY_InBus(cvy),
    .POS_LOOP_SCHEDULER_CTRLWZ_InBus(cwz),
    .POS_LOOP_SCHEDULER_VX_OutBus(vx),
    .POS_LOOP_SCHEDULER_VY_OutBus(vy),
    .POS_LOOP_SCHEDULER_WZ_OutBus(wz),
    .POS_LOOP_SCHEDULER_VALID_Out(valid),
    .POS_LOOP_SCHEDULER_ATGOAL_Out(atgoal),
    .POS_LOOP_SCHEDULER_OVERRUN_Out(ovr)
  );

  // Short period so that a tick lands while the FSM is still busy.
  pos_loop_scheduler #(.PERIOD_CYCLES(4), .SETTLE_CYCLES(2)) dut_ovr (
    .POS_LOOP_SCHEDULER_CLOCK_50(clk),
    .POS_LOOP_SCHEDULER_RESET_InLow(rst_n),
    .POS_LOOP_SCHEDULER_ENABLE_In(en2),
    .POS_LOOP_SCHEDULER_TARGETX_InBus(32'h0000_8000),
    .POS_LOOP_SCHEDULER_TARGETY_InBus(32'h0000_0000),
    .POS_LOOP_SCHEDULER_TARGETTHETA_InBus(32'h0000_0000),
    .POS_LOOP_SCHEDULER_CURRENTX_InBus(32'h0000_0000),
    .POS_LOOP_SCHEDULER_CURRENTY_InBus(32'h0000_0000),
    .POS_LOOP_SCHEDULER_CURRENTTHETA_InBus(32'h0000_0000),
    .POS_LOOP_SCHEDULER_SMPTARGETX_OutBus(d2_stx),
    .POS_LOOP_SCHEDULER_SMPTARGETY_OutBus(d2_sty),
    .POS_LOOP_SCHEDULER_SMPTARGETTHETA_OutBus(d2_stth),
    .POS_LOOP_SCHEDULER_SMPCURRENTX_OutBus(d2_scx),
    .POS_LOOP_SCHEDULER_SMPCURRENTY_OutBus(d2_scy),
    .POS_LOOP_SCHEDULER_SMPCURRENTTHETA_OutBus(d2_scth),
    .POS_LOOP_SCHEDULER_CTRLVX_InBus(32'h0000_4000),
    .POS_LOOP_SCHEDULER_CTRLVY_InBus(32'h0000_0000),
    .POS_LOOP_SCHEDULER_CTRLWZ_InBus(32'h0000_0000),
    .POS_LOOP_SCHEDULER_VX_OutBus(d2_vx),
    .POS_LOOP_SCHEDULER_VY_OutBus(d2_vy),
    .POS_LOOP_SCHEDULER_WZ_OutBus(d2_wz),
    .POS_LOOP_SCHEDULER_VALID_Out(d2_valid),
    .POS_LOOP_SCHEDULER_ATGOAL_Out(d2_atgoal),
    .POS_LOOP_SCHEDULER_OVERRUN_Out(d2_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The main instance always runs with a period well above its busy time.
  always @(negedge clk) begin
    if (ovr === 1'b1) ovr_seen <= 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, input int exp_edges);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((valid !== 1'b1) && (n < 40));
    check(name, 64'(n), 64'(exp_edges));
  endtask

  initial begin
    int          seen;
    logic [31:0] vmask, omask;
    n_tests  = 0;
    n_fail   = 0;
    ovr_seen = 1'b0;

    //         tx            ty            cx            cy            cvx           cvy           cwz           evx           evy           ewz           ag
    vecs[0] = '{32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'hFFFE_8000, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_8000, 1'b0};
    vecs[2] = '{32'h0000_00A4, 32'h0000_0000, 32'h0000_0000, 32'h0000_00A4, 32'h0000_4000, 32'h0000_2666, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0148, 32'h0000_0000, 32'h0000_0000, 32'h0000_0148, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0149, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 32'hFFFF_8000, 32'h0000_8001, 32'h0000_8000, 32'hFFFF_8000, 32'h0000_8000, 1'b0};
    vecs[5] = '{32'h0000_1000, 32'h7FFF_FFFF, 32'h0000_1000, 32'h8000_0000, 32'hFFFF_7FFF, 32'h0000_7FFF, 32'hFFFF_8000, 32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFF_8000, 1'b0};
    vecs[6] = '{32'hFFFF_FF00, 32'h8000_0000, 32'hFFFF_FE00, 32'h8000_0000, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

    rst_n = 1'b0;
    en    = 1'b1;
    en2   = 1'b0;
    tx = vecs[0].tx; ty = vecs[0].ty; cx = vecs[0].cx; cy = vecs[0].cy;
    cvx = vecs[0].cvx; cvy = vecs[0].cvy; cwz = vecs[0].cwz;
    tth = 32'h0000_0100;
    cth = 32'h0000_0000;

    #12;
    check("reset_vel", {vx | vy | wz, 32'h0}, 64'h0);
    check("reset_smp", {s_tx | s_ty | s_tth, s_cx | s_cy | s_cth}, 64'h0);
    check("reset_flags", {61'h0, valid, atgoal, ovr}, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      tx = vecs[i].tx; ty = vecs[i].ty; cx = vecs[i].cx; cy = vecs[i].cy;
      cvx = vecs[i].cvx; cvy = vecs[i].cvy; cwz = vecs[i].cwz;
      tth = 32'(i + 1) << 8;
      cth = 32'(i) << 4;
      wait_valid($sformatf("v%0d_latency", i), (i == 0) ? 14 : 9);
      check($sformatf("v%0d_vx", i), 64'(vx), 64'(vecs[i].evx));
      check($sformatf("v%0d_vy", i), 64'(vy), 64'(vecs[i].evy));
      check($sformatf("v%0d_wz", i), 64'(wz), 64'(vecs[i].ewz));
      check($sformatf("v%0d_atgoal", i), 64'(atgoal), 64'(vecs[i].eag));
      check($sformatf("v%0d_smp", i), {s_tth, s_cy}, {32'(i + 1) << 8, vecs[i].cy});
      wait_edges(1);
      check($sformatf("v%0d_valid_pulse", i), 64'(valid), 64'h0);
    end

    // Sample isolation: CURRENTX changes during SETTLE must wait for the next SAMPLE.
    tx = 32'h0000_8000; ty = 32'h0; cy = 32'h0;
    cvx = 32'h0000_4000; cvy = 32'h0; cwz = 32'h0;
    cx = 32'h0000_1234;
    wait_edges(6);
    check("iso_latched", 64'(s_cx), 64'h1234);
    cx = 32'h0000_5678;
    wait_edges(1);
    check("iso_settle_hold", 64'(s_cx), 64'h1234);
    wait_valid("iso_latency", 2);
    check("iso_capture_hold", 64'(s_cx), 64'h1234);
    check("iso_vx", 64'(vx), 64'h4000);
    wait_edges(7);
    check("iso_next_sample", 64'(s_cx), 64'h5678);

    // Disable while in SETTLE: no VALID, commands zeroed, samples held, period restarts.
    en = 1'b0;
    wait_edges(1);
    check("dis_vel_zero", {vx | vy | wz, 31'h0, valid}, 64'h0);
    check("dis_smp_hold", {s_tx, s_cx}, {32'h0000_8000, 32'h0000_5678});
    seen = 0;
    repeat (5) begin
      wait_edges(1);
      if (valid === 1'b1) seen++;
    end
    check("dis_no_valid", 64'(seen), 64'h0);
    en = 1'b1;
    wait_valid("dis_restart_latency", 14);
    check("dis_restart_vx", 64'(vx), 64'h4000);

    // Reset pulse in SETTLE: outputs clear at once, first VALID 14 edges after release.
    wait_edges(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_vel", {vx | vy | wz, 31'h0, valid}, 64'h0);
    check("rst_async_smp", {s_tx, s_cx}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("rst_release_latency", 14);
    check("rst_release_vx", 64'(vx), 64'h4000);
    check("main_no_overrun", 64'(ovr_seen), 64'h0);

    // Overrun: with a 4-cycle period every other tick arrives while in CAPTURE.
    vmask = '0;
    omask = '0;
    en2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wait_edges(1);
      vmask[k] = d2_valid;
      omask[k] = d2_ovr;
    end
    check("ovr_valid_edges", 64'(vmask), 64'h0001_0100);
    check("ovr_pulse_edges", 64'(omask), 64'h0001_0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
